// File: rtl/ctrl_pkg.sv
// Shared definitions for the microsequencer: state codes, opcodes,
// control-word constants, error codes and small state classifiers.
package ctrl_pkg;

  localparam int ST_BITS = 6;
  typedef logic [ST_BITS-1:0] st_t;

  localparam st_t S_IDLE   = 6'd0;
  localparam st_t S_FETCH1 = 6'd1;
  localparam st_t S_FETCH2 = 6'd2;
  localparam st_t S_FETCH3 = 6'd3;
  localparam st_t S_LDR11  = 6'd4;
  localparam st_t S_LDR12  = 6'd5;
  localparam st_t S_LDR13  = 6'd6;
  localparam st_t S_LDR14  = 6'd7;
  localparam st_t S_LDR21  = 6'd8;
  localparam st_t S_LDR22  = 6'd9;
  localparam st_t S_LDR23  = 6'd10;
  localparam st_t S_LDR24  = 6'd11;
  localparam st_t S_STAC1  = 6'd12;
  localparam st_t S_STAC2  = 6'd13;
  localparam st_t S_STAC3  = 6'd14;
  localparam st_t S_STAC4  = 6'd15;
  localparam st_t S_ADD1   = 6'd16;
  localparam st_t S_ADD2   = 6'd17;
  localparam st_t S_MUL    = 6'd18;
  localparam st_t S_JMP_T  = 6'd19;
  localparam st_t S_JMP_N  = 6'd20;
  localparam st_t S_HALTED = 6'd21;
  localparam st_t S_ERROR  = 6'd22;

  // Legal opcodes occupy the low three bits; anything above OP_HALT traps.
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDR1 = 3'd1;
  localparam logic [2:0] OP_LDR2 = 3'd2;
  localparam logic [2:0] OP_STAC = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_JMPZ = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [19:0] W_ZERO   = 20'd0;
  localparam logic [19:0] W_FETCH1 = 20'd135328;
  localparam logic [19:0] W_FETCH2 = 20'd147488;
  localparam logic [19:0] W_FETCH3 = 20'd133152;
  localparam logic [19:0] W_LDRX1  = 20'd36896;
  localparam logic [19:0] W_LDRX2  = 20'd32768;
  localparam logic [19:0] W_LDR1_3 = 20'd33024;
  localparam logic [19:0] W_LDR2_3 = 20'd33280;
  localparam logic [19:0] W_STAC1  = 20'd4128;
  localparam logic [19:0] W_STAC2  = 20'd65616;
  localparam logic [19:0] W_ADD    = 20'd1037;
  localparam logic [19:0] W_MUL    = 20'd1038;
  localparam logic [19:0] W_JMP_T  = 20'd2048;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // True in every state that belongs to an instruction in flight.
  function automatic logic st_busy(input st_t s);
    return !((s == S_IDLE) || (s == S_HALTED) || (s == S_ERROR));
  endfunction

  // States that wait on the memory ready handshake.
  function automatic logic st_mem_step(input st_t s);
    return (s == S_FETCH2) || (s == S_LDR12) || (s == S_LDR22) || (s == S_STAC2);
  endfunction

endpackage

// File: rtl/ctrl_word_rom.sv
// Combinational state -> control word lookup, zero-extended to CTRL_W.
module ctrl_word_rom
  import ctrl_pkg::*;
#(
  parameter int CTRL_W = 20
) (
  input  st_t               st,
  output logic [CTRL_W-1:0] word
);

  logic [19:0] w20;

  // One control word per state; unlisted states drive nothing.
  always_comb begin
    w20 = W_ZERO;
    case (st)
      S_FETCH1:                   w20 = W_FETCH1;
      S_FETCH2:                   w20 = W_FETCH2;
      S_FETCH3:                   w20 = W_FETCH3;
      S_LDR11, S_LDR21:           w20 = W_LDRX1;
      S_LDR12, S_LDR22:           w20 = W_LDRX2;
      S_LDR13, S_LDR14:           w20 = W_LDR1_3;
      S_LDR23, S_LDR24:           w20 = W_LDR2_3;
      S_STAC1:                    w20 = W_STAC1;
      S_STAC2, S_STAC3, S_STAC4:  w20 = W_STAC2;
      S_ADD1, S_ADD2:             w20 = W_ADD;
      S_MUL:                      w20 = W_MUL;
      S_JMP_T:                    w20 = W_JMP_T;
      default:                    w20 = W_ZERO;
    endcase
  end

  assign word = CTRL_W'(w20);

endmodule

// File: rtl/microsequencer_ctrl.sv
// Microsequencer: state register, opcode decode, memory-wait stretching
// with timeout, multi-cycle MUL and registered per-state control word.
module microsequencer_ctrl
  import ctrl_pkg::*;
#(
  parameter int CTRL_W     = 20,
  parameter int STATE_W    = 6,
  parameter int OPC_W      = 4,
  parameter int MUL_CYCLES = 3,
  parameter int WAIT_MAX   = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  input  logic               z_flag,
  output logic [CTRL_W-1:0]  control_out,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               instr_done,
  output logic               error,
  output logic [1:0]         err_code
);

  localparam int WAIT_CW = $clog2(WAIT_MAX + 1);

  generate
    if (CTRL_W < 20) begin : g_chk_ctrl_w
      $error("CTRL_W must be at least 20");
    end
    if (STATE_W < ST_BITS) begin : g_chk_state_w
      $error("STATE_W must be at least 6");
    end
    if (OPC_W < 3) begin : g_chk_opc_w
      $error("OPC_W must be at least 3");
    end
    if ((MUL_CYCLES < 1) || (MUL_CYCLES > 15)) begin : g_chk_mul
      $error("MUL_CYCLES must be in 1..15");
    end
    if (WAIT_MAX < 1) begin : g_chk_wait
      $error("WAIT_MAX must be at least 1");
    end
  endgenerate

  st_t                cur, nxt;
  logic [WAIT_CW-1:0] wait_cnt, wait_nxt;
  logic [3:0]         mul_cnt, mul_nxt;
  logic [1:0]         err_nxt;
  logic [CTRL_W-1:0]  word_nxt;

  // The word is looked up on the next state so it loads with the state.
  ctrl_word_rom #(.CTRL_W(CTRL_W)) u_rom (
    .st   (nxt),
    .word (word_nxt)
  );

  assign state = STATE_W'(cur);

  // State, counters and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur         <= S_IDLE;
      wait_cnt    <= '0;
      mul_cnt     <= '0;
      err_code    <= ERR_NONE;
      control_out <= '0;
      busy        <= 1'b0;
      error       <= 1'b0;
      instr_done  <= 1'b0;
    end else begin
      cur         <= nxt;
      wait_cnt    <= wait_nxt;
      mul_cnt     <= mul_nxt;
      err_code    <= err_nxt;
      control_out <= word_nxt;
      busy        <= st_busy(nxt);
      error       <= (nxt == S_ERROR);
      instr_done  <= (nxt == S_FETCH1) && st_busy(cur);
    end
  end

  // Next-state, counter and error-code logic.
  always_comb begin
    nxt      = cur;
    wait_nxt = '0;
    mul_nxt  = mul_cnt;
    err_nxt  = err_code;
    case (cur)
      S_IDLE: begin
        if (start) nxt = S_FETCH1;
      end
      S_HALTED, S_ERROR: begin
        if (start) begin
          nxt     = S_FETCH1;
          err_nxt = ERR_NONE;
        end
      end
      S_FETCH1: nxt = S_FETCH2;
      S_FETCH2: nxt = S_FETCH3;
      S_FETCH3: begin
        if (opcode > OPC_W'(OP_HALT)) begin
          nxt     = S_ERROR;
          err_nxt = ERR_ILLEGAL;
        end else begin
          case (opcode[2:0])
            OP_NOP:  nxt = S_FETCH1;
            OP_LDR1: nxt = S_LDR11;
            OP_LDR2: nxt = S_LDR21;
            OP_STAC: nxt = S_STAC1;
            OP_ADD:  nxt = S_ADD1;
            OP_MUL: begin
              nxt     = S_MUL;
              mul_nxt = 4'(MUL_CYCLES - 1);
            end
            OP_JMPZ: nxt = z_flag ? S_JMP_T : S_JMP_N;
            default: nxt = S_HALTED;
          endcase
        end
      end
      S_LDR11: nxt = S_LDR12;
      S_LDR12: nxt = S_LDR13;
      S_LDR13: nxt = S_LDR14;
      S_LDR14: nxt = S_FETCH1;
      S_LDR21: nxt = S_LDR22;
      S_LDR22: nxt = S_LDR23;
      S_LDR23: nxt = S_LDR24;
      S_LDR24: nxt = S_FETCH1;
      S_STAC1: nxt = S_STAC2;
      S_STAC2: nxt = S_STAC3;
      S_STAC3: nxt = S_STAC4;
      S_STAC4: nxt = S_FETCH1;
      S_ADD1:  nxt = S_ADD2;
      S_ADD2:  nxt = S_FETCH1;
      S_MUL: begin
        if (mul_cnt == 4'd0) nxt = S_FETCH1;
        else                 mul_nxt = mul_cnt - 4'd1;
      end
      S_JMP_T, S_JMP_N: nxt = S_FETCH1;
      default: nxt = S_IDLE;
    endcase

    // A memory step without ready holds, or traps once the budget is spent.
    if (st_mem_step(cur) && !mem_ready) begin
      if (wait_cnt == WAIT_CW'(WAIT_MAX)) begin
        nxt     = S_ERROR;
        err_nxt = ERR_TIMEOUT;
      end else begin
        nxt      = cur;
        wait_nxt = wait_cnt + WAIT_CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_microsequencer_ctrl.sv
// Self-checking bench for microsequencer_ctrl: directed scenarios plus a
// randomized instruction stream checked against a sequence-level model.
module tb_microsequencer_ctrl;
  import ctrl_pkg::*;

  localparam int CTRL_W     = 20;
  localparam int STATE_W    = 6;
  localparam int OPC_W      = 4;
  localparam int MUL_CYCLES = 3;
  localparam int WAIT_MAX   = 15;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [OPC_W-1:0]   opcode = '0;
  logic               mem_ready = 1'b1;
  logic               z_flag = 1'b0;
  logic [CTRL_W-1:0]  control_out;
  logic [STATE_W-1:0] state;
  logic               busy, instr_done, error;
  logic [1:0]         err_code;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_q[$];
  int exp_err;
  logic [STATE_W-1:0] rec_st[$];
  logic [CTRL_W-1:0]  rec_w[$];
  logic rec_done[$], rec_busy[$], rec_err[$];

  microsequencer_ctrl #(
    .CTRL_W(CTRL_W), .STATE_W(STATE_W), .OPC_W(OPC_W),
    .MUL_CYCLES(MUL_CYCLES), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
    .mem_ready(mem_ready), .z_flag(z_flag), .control_out(control_out),
    .state(state), .busy(busy), .instr_done(instr_done), .error(error),
    .err_code(err_code)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int word_of(input int s);
    case (s)
      S_FETCH1: return 135328;
      S_FETCH2: return 147488;
      S_FETCH3: return 133152;
      S_LDR11, S_LDR21: return 36896;
      S_LDR12, S_LDR22: return 32768;
      S_LDR13, S_LDR14: return 33024;
      S_LDR23, S_LDR24: return 33280;
      S_STAC1: return 4128;
      S_STAC2, S_STAC3, S_STAC4: return 65616;
      S_ADD1, S_ADD2: return 1037;
      S_MUL: return 1038;
      S_JMP_T: return 2048;
      default: return 0;
    endcase
  endfunction

  function automatic bit busy_of(input int s);
    return !(s == S_IDLE || s == S_HALTED || s == S_ERROR);
  endfunction

  // A memory step shows once plus once per stall, or traps after WAIT_MAX+1 stalls.
  task automatic model_mem(input int s, input int stalls, output bit died);
    died = 1'b0;
    if (stalls > WAIT_MAX) begin
      repeat (WAIT_MAX + 1) exp_q.push_back(s);
      exp_q.push_back(S_ERROR);
      exp_err = 2;
      died = 1'b1;
    end else begin
      repeat (stalls + 1) exp_q.push_back(s);
    end
  endtask

  // Expected state sequence for one instruction, starting at its FETCH1.
  task automatic build_model(input int opc, input int z, input int sf2, input int sm);
    bit died;
    exp_q.delete();
    exp_err = 0;
    exp_q.push_back(S_FETCH1);
    model_mem(S_FETCH2, sf2, died);
    if (died) return;
    exp_q.push_back(S_FETCH3);
    case (opc)
      0: ;
      1: begin
        exp_q.push_back(S_LDR11); model_mem(S_LDR12, sm, died);
        if (died) return;
        exp_q.push_back(S_LDR13); exp_q.push_back(S_LDR14);
      end
      2: begin
        exp_q.push_back(S_LDR21); model_mem(S_LDR22, sm, died);
        if (died) return;
        exp_q.push_back(S_LDR23); exp_q.push_back(S_LDR24);
      end
      3: begin
        exp_q.push_back(S_STAC1); model_mem(S_STAC2, sm, died);
        if (died) return;
        exp_q.push_back(S_STAC3); exp_q.push_back(S_STAC4);
      end
      4: begin exp_q.push_back(S_ADD1); exp_q.push_back(S_ADD2); end
      5: repeat (MUL_CYCLES) exp_q.push_back(S_MUL);
      6: exp_q.push_back(z != 0 ? S_JMP_T : S_JMP_N);
      7: begin exp_q.push_back(S_HALTED); return; end
      default: begin exp_q.push_back(S_ERROR); exp_err = 1; return; end
    endcase
    exp_q.push_back(S_FETCH1);
  endtask

  // Drives one instruction from a visible FETCH1 and records every cycle.
  task automatic exec(input int opc, input int z, input int sf2, input int sm, input bit noise);
    int f2_left, m_left;
    build_model(opc, z, sf2, sm);
    rec_st.delete(); rec_w.delete(); rec_done.delete(); rec_busy.delete(); rec_err.delete();
    f2_left = sf2;
    m_left  = sm;
    opcode  = OPC_W'(opc);
    z_flag  = z[0];
    for (int i = 0; i < exp_q.size(); i++) begin
      rec_st.push_back(state);
      rec_w.push_back(control_out);
      rec_done.push_back(instr_done);
      rec_busy.push_back(busy);
      rec_err.push_back(error);
      if (i == exp_q.size() - 1) break;
      mem_ready = 1'b1;
      if (state == S_FETCH2 && f2_left > 0) begin
        mem_ready = 1'b0; f2_left--;
      end else if ((state == S_LDR12 || state == S_LDR22 || state == S_STAC2) && m_left > 0) begin
        mem_ready = 1'b0; m_left--;
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clock); #1;
    end
    start = 1'b0;
    mem_ready = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (state !== STATE_W'(S_IDLE)) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, S_IDLE); end
    n_checks++;
    if (control_out !== '0) begin n_fail++; $display("FAIL reset_word: got %0d want 0", control_out); end
    n_checks++;
    if ({busy, instr_done, error, err_code} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: busy=%b done=%b error=%b err_code=%0d want all 0", busy, instr_done, error, err_code);
    end
  endtask

  task automatic test_add();
    int exp_s[6];
    int exp_w[6];
    int dones;
    exp_s = '{S_FETCH1, S_FETCH2, S_FETCH3, S_ADD1, S_ADD2, S_FETCH1};
    exp_w = '{135328, 147488, 133152, 1037, 1037, 135328};
    opcode = 4'd4;
    do_start();
    n_checks++;
    if (state !== STATE_W'(S_FETCH1) || instr_done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL start_fetch: state=%0d done=%b busy=%b want %0d 0 1", state, instr_done, busy, S_FETCH1);
    end
    exec(4, 0, 0, 0, 1'b0);
    n_checks++;
    if (rec_st.size() != 6) begin n_fail++; $display("FAIL add_len: got %0d want 6", rec_st.size()); end
    dones = 0;
    for (int i = 0; i < 6 && i < rec_st.size(); i++) begin
      n_checks++;
      if (rec_st[i] !== STATE_W'(exp_s[i]) || rec_w[i] !== CTRL_W'(exp_w[i])) begin
        n_fail++; $display("FAIL add_seq[%0d]: state=%0d word=%0d want %0d %0d", i, rec_st[i], rec_w[i], exp_s[i], exp_w[i]);
      end
      if (i > 0 && rec_done[i] === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 1 || rec_done[5] !== 1'b1) begin
      n_fail++; $display("FAIL add_instr_done: pulses=%0d last=%b want 1 1", dones, rec_done[5]);
    end
  endtask

  task automatic test_ldr_stall();
    int held;
    exec(1, 0, 0, 3, 1'b0);
    held = 0;
    for (int i = 0; i < rec_st.size(); i++) begin
      if (rec_st[i] === STATE_W'(S_LDR12)) begin
        held++;
        n_checks++;
        if (rec_w[i] !== CTRL_W'(32768)) begin n_fail++; $display("FAIL ldr12_word: got %0d want 32768", rec_w[i]); end
      end
    end
    n_checks++;
    if (held != 4) begin n_fail++; $display("FAIL ldr12_hold: got %0d cycles want 4", held); end
    n_checks++;
    if (rec_st.size() < 9 || rec_st[8] !== STATE_W'(S_LDR13) || rec_w[8] !== CTRL_W'(33024)) begin
      n_fail++; $display("FAIL ldr13_after_stall: size=%0d state=%0d word=%0d want %0d 33024",
                         rec_st.size(), rec_st[8], rec_w[8], S_LDR13);
    end
  endtask

  task automatic test_timeout();
    int held;
    exec(0, 0, WAIT_MAX + 1, 0, 1'b0);
    held = 0;
    foreach (rec_st[i]) if (rec_st[i] === STATE_W'(S_FETCH2)) held++;
    n_checks++;
    if (held != WAIT_MAX + 1) begin n_fail++; $display("FAIL timeout_stall_count: got %0d want %0d", held, WAIT_MAX + 1); end
    n_checks++;
    if (state !== STATE_W'(S_ERROR) || error !== 1'b1 || err_code !== 2'd2 || control_out !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_error: state=%0d error=%b err_code=%0d word=%0d busy=%b want %0d 1 2 0 0",
                         state, error, err_code, control_out, busy, S_ERROR);
    end
    do_start();
    n_checks++;
    if (state !== STATE_W'(S_FETCH1) || err_code !== 2'd0 || error !== 1'b0) begin
      n_fail++; $display("FAIL timeout_restart: state=%0d err_code=%0d error=%b want %0d 0 0", state, err_code, error, S_FETCH1);
    end
  endtask

  task automatic test_illegal_halt();
    exec(9, 0, 0, 0, 1'b0);
    n_checks++;
    if (state !== STATE_W'(S_ERROR) || err_code !== 2'd1 || error !== 1'b1 || control_out !== '0) begin
      n_fail++; $display("FAIL illegal_trap: state=%0d err_code=%0d error=%b word=%0d want %0d 1 1 0",
                         state, err_code, error, control_out, S_ERROR);
    end
    do_start();
    exec(7, 0, 0, 0, 1'b0);
    n_checks++;
    if (state !== STATE_W'(S_HALTED) || busy !== 1'b0 || err_code !== 2'd0 || control_out !== '0) begin
      n_fail++; $display("FAIL halt_state: state=%0d busy=%b err_code=%0d word=%0d want %0d 0 0 0",
                         state, busy, err_code, control_out, S_HALTED);
    end
    do_start();
    n_checks++;
    if (state !== STATE_W'(S_FETCH1) || instr_done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL halt_resume: state=%0d done=%b busy=%b want %0d 0 1", state, instr_done, busy, S_FETCH1);
    end
  endtask

  task automatic test_mul_jmpz();
    int held;
    exec(5, 0, 0, 0, 1'b0);
    held = 0;
    foreach (rec_st[i]) if (rec_st[i] === STATE_W'(S_MUL) && rec_w[i] === CTRL_W'(1038)) held++;
    n_checks++;
    if (held != MUL_CYCLES || rec_st[rec_st.size()-1] !== STATE_W'(S_FETCH1)) begin
      n_fail++; $display("FAIL mul_hold: got %0d cycles at 1038 want %0d", held, MUL_CYCLES);
    end
    exec(6, 1, 0, 0, 1'b0);
    n_checks++;
    if (rec_st[3] !== STATE_W'(S_JMP_T) || rec_w[3] !== CTRL_W'(2048) || rec_st[4] !== STATE_W'(S_FETCH1)) begin
      n_fail++; $display("FAIL jmpz_taken: state=%0d word=%0d want %0d 2048", rec_st[3], rec_w[3], S_JMP_T);
    end
    exec(6, 0, 0, 0, 1'b0);
    n_checks++;
    if (rec_st[3] !== STATE_W'(S_JMP_N) || rec_w[3] !== CTRL_W'(0) || rec_st[4] !== STATE_W'(S_FETCH1)) begin
      n_fail++; $display("FAIL jmpz_not_taken: state=%0d word=%0d want %0d 0", rec_st[3], rec_w[3], S_JMP_N);
    end
  endtask

  task automatic test_random();
    int opc, z, sf2, sm, last;
    for (int n = 0; n < 60; n++) begin
      opc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
      z   = int'($urandom_range(0, 1));
      sf2 = ($urandom_range(0, 15) == 0) ? WAIT_MAX + 1 : int'($urandom_range(0, 2));
      sm  = ($urandom_range(0, 15) == 0) ? WAIT_MAX + 1 : int'($urandom_range(0, 3));
      exec(opc, z, sf2, sm, 1'b1);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (rec_st[i] !== STATE_W'(exp_q[i]) || rec_w[i] !== CTRL_W'(word_of(exp_q[i])) ||
            rec_busy[i] !== busy_of(exp_q[i]) || rec_err[i] !== (exp_q[i] == S_ERROR) ||
            (i > 0 && rec_done[i] !== (exp_q[i] == S_FETCH1))) begin
          n_fail++;
          $display("FAIL rand_cycle op=%0d n=%0d cyc=%0d: state=%0d word=%0d busy=%b err=%b done=%b want state=%0d word=%0d",
                   opc, n, i, rec_st[i], rec_w[i], rec_busy[i], rec_err[i], rec_done[i], exp_q[i], word_of(exp_q[i]));
        end
      end
      last = exp_q[exp_q.size()-1];
      if (last != S_FETCH1) begin
        n_checks++;
        if (err_code !== 2'(exp_err)) begin
          n_fail++; $display("FAIL rand_err_code op=%0d: got %0d want %0d", opc, err_code, exp_err);
        end
        do_start();
        n_checks++;
        if (state !== STATE_W'(S_FETCH1) || err_code !== 2'd0 || instr_done !== 1'b0) begin
          n_fail++; $display("FAIL rand_restart: state=%0d err_code=%0d done=%b want %0d 0 0", state, err_code, instr_done, S_FETCH1);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    opcode = 4'd3;
    mem_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (state === STATE_W'(S_STAC3)) begin found = 1'b1; break; end
      @(posedge clock); #1;
    end
    n_checks++;
    if (!found || control_out !== CTRL_W'(65616)) begin
      n_fail++; $display("FAIL reach_stac3: found=%0d word=%0d want 1 65616", found, control_out);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (state !== STATE_W'(S_IDLE) || control_out !== '0 ||
        {busy, instr_done, error, err_code} !== 5'b0) begin
      n_fail++; $display("FAIL async_reset: state=%0d word=%0d busy=%b done=%b error=%b err_code=%0d want all 0",
                         state, control_out, busy, instr_done, error, err_code);
    end
    #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      n_checks++;
      if (state !== STATE_W'(S_IDLE) || control_out !== '0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_after_reset: state=%0d word=%0d busy=%b want %0d 0 0", state, control_out, busy, S_IDLE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr_stall();
    test_timeout();
    test_illegal_halt();
    test_mul_jmpz();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
